// File: rtl/des_round_engine.sv
// Iterative DES round core: one Feistel round per clock over 16 rounds, with the key
// schedule rotated in place. The round function f is supplied externally and combinationally.
module des_round_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
   input  logic        in_decrypt,
   output logic [31:0] f_r,
   output logic [47:0] f_k,
   input  logic [31:0] f_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   // state   | meaning
   // IDLE    | waiting for a block; in_ready high
   // ROUND   | Feistel rounds 0..15, one per cycle
   // DONE    | result held on out_data until out_ready
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Tables use FIPS 1-based bit numbering, bit 1 being the MSB.
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   function automatic logic [55:0] pc1 (input logic [63:0] key);
      logic [55:0] res;
      logic [5:0]  idx;
      res = '0;
      for (int j = 0; j < 56; j++) begin
         idx = 6'(64 - PC1_TAB[j]);
         res = {res[54:0], key[idx]};
      end
      return res;
   endfunction

   function automatic logic [47:0] pc2 (input logic [55:0] cd);
      logic [47:0] res;
      logic [5:0]  idx;
      res = '0;
      for (int j = 0; j < 48; j++) begin
         idx = 6'(56 - PC2_TAB[j]);
         res = {res[46:0], cd[idx]};
      end
      return res;
   endfunction

   // Decrypt walks the schedule backwards, so round 0 reuses the loaded C/D (K16).
   function automatic logic [1:0] shift_amt (input logic [3:0] rnd, input logic dec);
      logic [1:0] amt;
      if (rnd == 4'd0)
         amt = dec ? 2'd0 : 2'd1;
      else if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15)
         amt = 2'd1;
      else
         amt = 2'd2;
      return amt;
   endfunction

   function automatic logic [27:0] rot28 (input logic [27:0] x, input logic [1:0] amt,
                                          input logic right);
      logic [27:0] res;
      case (amt)
         2'd1:    res = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
         2'd2:    res = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
         default: res = x;
      endcase
      return res;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [3:0]  round_q, round_d;
   logic [31:0] l_q, l_d;
   logic [31:0] r_q, r_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic        mode_q, mode_d;
   logic [63:0] out_q, out_d;

   logic [1:0]  amt;
   logic [27:0] c_n;
   logic [27:0] d_n;
   logic [47:0] subkey;
   logic [55:0] cd_load;
   logic        in_round;

   always_comb begin
      amt      = shift_amt(round_q, mode_q);
      c_n      = rot28(c_q, amt, mode_q);
      d_n      = rot28(d_q, amt, mode_q);
      subkey   = pc2({c_n, d_n});
      cd_load  = pc1(in_key);
      in_round = (state_q == S_ROUND);
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      mode_d  = mode_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               l_d     = in_data[63:32];
               r_d     = in_data[31:0];
               c_d     = cd_load[55:28];
               d_d     = cd_load[27:0];
               mode_d  = in_decrypt;
               round_d = 4'd0;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            c_d     = c_n;
            d_d     = d_n;
            l_d     = r_q;
            r_d     = l_q ^ f_out;
            round_d = round_q + 4'd1;
            // Last round skips the swap, giving {R16,L16} for the final permutation.
            if (round_q == 4'd15) begin
               out_d   = {l_q ^ f_out, r_q};
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         round_q <= '0;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         mode_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_q;
   assign f_r       = in_round ? r_q : 32'd0;
   assign f_k       = in_round ? subkey : 48'd0;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine; the DES f-function is modelled here and fed back
// combinationally on f_out.
module tb_des_round_engine;

   localparam int E_TAB [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
   };

   localparam int P_TAB [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   localparam int SBOX [512] = '{
      14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,

      15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,

      10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,

       7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,

       2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,

      12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,

       4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,

      13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
   };

   localparam logic [63:0] KEY1   = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT1    = 64'hCC00CCFFF0AAF0AA;
   localparam logic [63:0] CT1    = 64'h0A4CD99543423234;
   localparam logic [47:0] K1_ENC = 48'h1B02EFFC7072;
   localparam logic [47:0] K1_DEC = 48'hCB3D8B0E17F5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic [63:0] in_key = '0;
   logic        in_decrypt = 1'b0;
   logic [31:0] f_r;
   logic [47:0] f_k;
   logic [31:0] f_out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic        busy;

   int n_vec  = 0;
   int n_miss = 0;

   des_round_engine dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .f_r        (f_r),
      .f_k        (f_k),
      .f_out      (f_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] des_f (input logic [31:0] r, input logic [47:0] k);
      logic [47:0] e;
      logic [31:0] s;
      logic [31:0] p;
      logic [5:0]  b;
      int          idx;
      e = '0;
      for (int j = 0; j < 48; j++) e = {e[46:0], r[5'(32 - E_TAB[j])]};
      e = e ^ k;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         b   = e[47:42];
         e   = e << 6;
         idx = i * 64 + int'({b[5], b[0]}) * 16 + int'(b[4:1]);
         s   = {s[27:0], 4'(SBOX[idx])};
      end
      p = '0;
      for (int j = 0; j < 32; j++) p = {p[30:0], s[5'(32 - P_TAB[j])]};
      return p;
   endfunction

   always_comb f_out = des_f(f_r, f_k);

   task automatic chk (input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out (input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 64'(out_valid), 64'd1);
   endtask

   task automatic run_block (input logic [63:0] k, input logic [63:0] d, input logic dec,
                             output logic [63:0] res);
      int n;
      in_key     = k;
      in_data    = d;
      in_decrypt = dec;
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      wait_out("run_done");
      res       = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [63:0] held;
   logic [63:0] ct;
   logic [63:0] pt;
   logic [63:0] rt_key  [4];
   logic [63:0] rt_data [4];

   initial begin
      rt_key[0]  = 64'h0123456789ABCDEF; rt_data[0] = 64'h0000000000000000;
      rt_key[1]  = 64'hFEDCBA9876543210; rt_data[1] = 64'hFFFFFFFFFFFFFFFF;
      rt_key[2]  = 64'h0E329232EA6D0D73; rt_data[2] = 64'h8787878787878787;
      rt_key[3]  = 64'hA5A5A5A55A5A5A5A; rt_data[3] = 64'h0123456789ABCDEF;

      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_out_data",  out_data,       64'd0);
      chk("rst_f_k",       64'(f_k),       64'd0);
      chk("rst_f_r",       64'(f_r),       64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Encrypt vector with round-0 probes and exact latency.
      in_key = KEY1; in_data = PT1; in_decrypt = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("enc_r0_f_k",   64'(f_k),      64'(K1_ENC));
      chk("enc_r0_f_r",   64'(f_r),      64'(PT1[31:0]));
      chk("enc_busy",     64'(busy),     64'd1);
      chk("enc_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 15; i++) tick();
      chk("enc_not_early", 64'(out_valid), 64'd0);
      tick();
      chk("enc_valid_t16", 64'(out_valid), 64'd1);
      chk("enc_out_data",  out_data,       CT1);

      // Output held under backpressure; a new in_valid must not disturb it.
      held = out_data;
      in_key = 64'hFFFFFFFFFFFFFFFF; in_data = 64'h1111111111111111; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_out_data",  out_data,        held);
         chk("bp_in_ready",  64'(in_ready),   64'd0);
         chk("bp_out_valid", 64'(out_valid),  64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_idle", 64'(in_ready), 64'd1);
      chk("bp_release_ov",   64'(out_valid), 64'd0);

      // Decrypt vector: first subkey is K16.
      in_key = KEY1; in_data = CT1; in_decrypt = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("dec_r0_f_k", 64'(f_k), 64'(K1_DEC));
      wait_out("dec_done");
      chk("dec_out_data", out_data, PT1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Back-to-back with in_valid held across the output handshake.
      out_ready = 1'b1;
      in_key = KEY1; in_data = PT1; in_decrypt = 1'b0; in_valid = 1'b1;
      tick();
      in_data = CT1; in_decrypt = 1'b1;
      wait_out("b2b_first_done");
      chk("b2b_first_data", out_data, CT1);
      tick();
      chk("b2b_gap_in_ready", 64'(in_ready), 64'd1);
      chk("b2b_gap_busy",     64'(busy),     64'd0);
      tick();
      chk("b2b_second_busy", 64'(busy), 64'd1);
      chk("b2b_second_f_k",  64'(f_k),  64'(K1_DEC));
      in_valid = 1'b0;
      wait_out("b2b_second_done");
      chk("b2b_second_data", out_data, PT1);
      tick();
      out_ready = 1'b0;

      // Asynchronous reset in the middle of round 7.
      in_key = KEY1; in_data = PT1; in_decrypt = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready",  64'(in_ready),  64'd1);
      chk("midrst_busy",      64'(busy),      64'd0);
      chk("midrst_out_data",  out_data,       64'd0);
      tick();
      rst = 1'b0;
      tick();
      run_block(KEY1, PT1, 1'b0, ct);
      chk("rerun_out_data", ct, CT1);

      // Round trips on further keys and blocks.
      for (int i = 0; i < 4; i++) begin
         run_block(rt_key[i], rt_data[i], 1'b0, ct);
         run_block(rt_key[i], ct, 1'b1, pt);
         chk("roundtrip", pt, rt_data[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
